dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported data memory (`dmem`). It shares the memory between the core load/store unit (port 0) and a loader/debug DMA master (port 1) using a valid/grant handshake with round-robin fairness. It registers the winning request onto the memory bus and returns read data with a fixed latency. It sits between the core's memory stage and `dmem`, and drives `dmem`'s `r_w`, `mem_addr` and `mem_data`, and samples its `mem_out`.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arbiter_rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the dmem_arbiter slice (port indices,
// lock-state encoding, issued-beat record).
package dmem_arb_pkg;

  localparam int unsigned ARB_AW = 32;
  localparam int unsigned ARB_DW = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    OWNED0 = 2'd1,
    OWNED1 = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic              port;
  } beat_t;

  function automatic lock_state_e owned_state(input logic port);
    return (port == PORT_DMA) ? OWNED1 : OWNED0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-requester round-robin picker. Only requesters enabled in
// mask compete; on a tie the port other than last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req & mask;
    gnt      = '0;
    case (eligible)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported dmem: grant, S1
// issue register onto the memory bus, S2 read-response demux.
// Optional ownership lock for atomic sequences: define DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = ARB_AW,
  parameter int unsigned DW = ARB_DW
) (
  input  logic          clk,
  input  logic          reset_n,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,

  output logic          mem_r_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_out
);

  logic [1:0]    req;
  logic [1:0]    mask;
  logic [1:0]    arb_gnt;
  logic [1:0]    gnt;
  logic          accept;
  logic          acc_port;

  logic          last_q, last_d;
  logic          s1_v_q, s1_v_d;
  beat_t         s1_q, s1_d;
  logic          s2_v_q, s2_v_d;
  logic          s2_port_q, s2_port_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          rvalid0_int, rvalid1_int;

`ifdef DMEM_ARB_LOCK_EN
  lock_state_e   lock_q, lock_d;
  logic          acc_lock;
`else
  logic          unused_lock;
`endif

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .mask (mask),
    .gnt  (arb_gnt)
  );

  // Arbitration front end. Grants are forced low while reset is asserted so
  // nothing is accepted in a cycle whose state is about to be discarded.
  always_comb begin
    req = {req1, req0};
`ifdef DMEM_ARB_LOCK_EN
    case (lock_q)
      OWNED0:  mask = 2'b01;
      OWNED1:  mask = 2'b10;
      default: mask = 2'b11;
    endcase
`else
    mask = 2'b11;
`endif
    gnt      = reset_n ? arb_gnt : '0;
    accept   = |gnt;
    acc_port = gnt[1];
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

`ifdef DMEM_ARB_LOCK_EN
  always_comb begin
    lock_d   = lock_q;
    acc_lock = (acc_port == PORT_DMA) ? lock1 : lock0;
    if (accept) begin
      case (lock_q)
        FREE:    if (acc_lock)  lock_d = owned_state(acc_port);
        OWNED0,
        OWNED1:  if (!acc_lock) lock_d = FREE;
        default: lock_d = FREE;
      endcase
    end
  end
`else
  assign unused_lock = lock0 | lock1;
`endif

  // Issue stage: capture the winning beat; address/data hold when idle.
  always_comb begin
    last_d = last_q;
    s1_v_d = accept;
    s1_d   = s1_q;
    if (accept) begin
      last_d = acc_port;
      if (acc_port == PORT_DMA) begin
        s1_d.we    = we1;
        s1_d.addr  = ARB_AW'(addr1);
        s1_d.wdata = ARB_DW'(wdata1);
      end else begin
        s1_d.we    = we0;
        s1_d.addr  = ARB_AW'(addr0);
        s1_d.wdata = ARB_DW'(wdata0);
      end
      s1_d.port = acc_port;
    end
  end

  // Memory-side write strobe is also gated by reset so an in-flight write is
  // dropped rather than committed during the reset cycle.
  always_comb begin
    mem_r_w  = s1_v_q && s1_q.we && reset_n;
    mem_addr = s1_q.addr[AW-1:0];
    mem_data = s1_q.wdata[DW-1:0];
  end

  // Response stage: the synchronous-read dmem presents mem_out in S2, so the
  // selected rdata passes it straight through and keeps it afterwards.
  always_comb begin
    s2_v_d      = s1_v_q && !s1_q.we;
    s2_port_d   = s1_q.port;
    rvalid0_int = reset_n && s2_v_q && (s2_port_q == PORT_CORE);
    rvalid1_int = reset_n && s2_v_q && (s2_port_q == PORT_DMA);
    rdata0_d    = rvalid0_int ? mem_out : rdata0_q;
    rdata1_d    = rvalid1_int ? mem_out : rdata1_q;
  end

  assign rvalid0 = rvalid0_int;
  assign rvalid1 = rvalid1_int;
  assign rdata0  = rdata0_d;
  assign rdata1  = rdata1_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q    <= PORT_DMA;
      s1_v_q    <= 1'b0;
      s1_q      <= '0;
      s2_v_q    <= 1'b0;
      s2_port_q <= PORT_CORE;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      last_q    <= last_d;
      s1_v_q    <= s1_v_d;
      s1_q      <= s1_d;
      s2_v_q    <= s2_v_d;
      s2_port_q <= s2_port_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_q <= FREE;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a synchronous-read dmem model.
// Lock sequence expectations switch on DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_r_w;
  logic [31:0] rdata0, rdata1, mem_addr, mem_data, mem_out;

  int vectors_applied = 0;
  int miscompares     = 0;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .lock0    (lock0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .lock1    (lock1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .mem_r_w  (mem_r_w),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_out  (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem stand-in: word = 0xA500_0000 | byte address, except 0x4 = 0xDEADBEEF.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'hA500_0000 | (i << 2);
      mem[1]  <= 32'hDEAD_BEEF;
      mem_out <= '0;
    end else begin
      if (mem_r_w) mem[mem_addr[15:2]] <= mem_data;
      mem_out <= mem[mem_addr[15:2]];
    end
  end

  typedef struct {
    logic        rst_n;
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic        g0, g1, rv0, rv1, rw;
    logic [31:0] rd0, rd1, ma, md;
    logic        full;
  } vec_t;

  function automatic vec_t v(input logic rst, r0, w0, input logic [31:0] a0, d0,
                             input logic r1, w1, input logic [31:0] a1, d1,
                             input logic g0, g1, rv0, rv1, input logic [31:0] rd0, rd1,
                             input logic rw, input logic [31:0] ma, md);
    vec_t t;
    t.rst_n = rst; t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0; t.l0 = 1'b0;
    t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1; t.l1 = 1'b0;
    t.g0 = g0; t.g1 = g1; t.rv0 = rv0; t.rv1 = rv1; t.rd0 = rd0; t.rd1 = rd1;
    t.rw = rw; t.ma = ma; t.md = md; t.full = 1'b1;
    return t;
  endfunction

  // Grant-only vector; port 1 always issues a read of 0x200 when requesting.
  function automatic vec_t vl(input logic r0, w0, input logic [31:0] a0, d0,
                              input logic l0, r1, g0, g1);
    vec_t t;
    t = v(1'b1, r0, w0, a0, d0, r1, 1'b0, 32'h200, 32'h0,
          g0, g1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    t.l0   = l0;
    t.full = 1'b0;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    reset_n = t.rst_n;
    req0 = t.r0; we0 = t.w0; addr0 = t.a0; wdata0 = t.d0; lock0 = t.l0;
    req1 = t.r1; we1 = t.w1; addr1 = t.a1; wdata1 = t.d1; lock1 = t.l1;
    @(negedge clk);
    vectors_applied++;
    chk("gnt0", idx, {31'b0, gnt0}, {31'b0, t.g0});
    chk("gnt1", idx, {31'b0, gnt1}, {31'b0, t.g1});
    if (t.full) begin
      chk("rvalid0",  idx, {31'b0, rvalid0}, {31'b0, t.rv0});
      chk("rvalid1",  idx, {31'b0, rvalid1}, {31'b0, t.rv1});
      chk("rdata0",   idx, rdata0, t.rd0);
      chk("rdata1",   idx, rdata1, t.rd1);
      chk("mem_r_w",  idx, {31'b0, mem_r_w}, {31'b0, t.rw});
      chk("mem_addr", idx, mem_addr, t.ma);
      chk("mem_data", idx, mem_data, t.md);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] WD = 32'h1234_5678;

  initial begin
    vec_t tbl[$];

    // reset with both ports requesting
    tbl.push_back(v(0, 1,0,32'h4,0, 1,0,32'h200,0, 0,0,0,0, 0,0, 0,32'h0,0));
    tbl.push_back(v(0, 1,0,32'h4,0, 1,0,32'h200,0, 0,0,0,0, 0,0, 0,32'h0,0));
    // first tie after reset goes to port 0; port 1 withdraws; single read
    tbl.push_back(v(1, 1,0,32'h4,0, 1,0,32'h200,0, 1,0,0,0, 0,0, 0,32'h0,0));
    tbl.push_back(v(1, 0,0,0,0,     0,0,0,0,       0,0,0,0, 0,0, 0,32'h4,0));
    tbl.push_back(v(1, 0,0,0,0,     0,0,0,0,       0,0,1,0, DB,0, 0,32'h4,0));
    tbl.push_back(v(1, 0,0,0,0,     0,0,0,0,       0,0,0,0, DB,0, 0,32'h4,0));
    // port 1 write then read-back of the same address
    tbl.push_back(v(1, 0,0,0,0, 1,1,32'h8010,WD, 0,1,0,0, DB,0,  0,32'h4,0));
    tbl.push_back(v(1, 0,0,0,0, 1,0,32'h8010,0,  0,1,0,0, DB,0,  1,32'h8010,WD));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0,         0,0,0,0, DB,0,  0,32'h8010,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0,         0,0,0,1, DB,WD, 0,32'h8010,0));
    // six cycles of contention, each port holds its address until granted
    tbl.push_back(v(1, 1,0,32'h100,0, 1,0,32'h200,0, 1,0,0,0, DB,WD, 0,32'h8010,0));
    tbl.push_back(v(1, 1,0,32'h104,0, 1,0,32'h200,0, 0,1,0,0, DB,WD, 0,32'h100,0));
    tbl.push_back(v(1, 1,0,32'h104,0, 1,0,32'h204,0, 1,0,1,0, 32'hA500_0100,WD, 0,32'h200,0));
    tbl.push_back(v(1, 1,0,32'h108,0, 1,0,32'h204,0, 0,1,0,1, 32'hA500_0100,32'hA500_0200, 0,32'h104,0));
    tbl.push_back(v(1, 1,0,32'h108,0, 1,0,32'h208,0, 1,0,1,0, 32'hA500_0104,32'hA500_0200, 0,32'h204,0));
    tbl.push_back(v(1, 1,0,32'h10C,0, 1,0,32'h208,0, 0,1,0,1, 32'hA500_0104,32'hA500_0204, 0,32'h108,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,1,0, 32'hA500_0108,32'hA500_0204, 0,32'h208,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,0,1, 32'hA500_0108,32'hA500_0208, 0,32'h208,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 32'hA500_0108,32'hA500_0208, 0,32'h208,0));
    // port 1 read granted, reset asserted the next cycle
    tbl.push_back(v(1, 0,0,0,0, 1,0,32'h200,0, 0,1,0,0, 32'hA500_0108,32'hA500_0208, 0,32'h208,0));
    tbl.push_back(v(0, 0,0,0,0, 0,0,0,0,       0,0,0,0, 32'hA500_0108,32'hA500_0208, 0,32'h200,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0,       0,0,0,0, 0,0, 0,32'h0,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0,       0,0,0,0, 0,0, 0,32'h0,0));
    // last restored to port 1 by reset: tie goes to port 0 again
    tbl.push_back(v(1, 1,0,32'h4,0, 1,0,32'h200,0, 1,0,0,0, 0,0, 0,32'h0,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,  0,32'h4,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,1,0, DB,0, 0,32'h4,0));

    // read(lock0=1), gap, write(lock0=0) by port 0 with port 1 always requesting
`ifdef DMEM_ARB_LOCK_EN
    tbl.push_back(vl(0,0,32'h0,0,           0, 1, 0,1));
    tbl.push_back(vl(1,0,32'h4,0,           1, 1, 1,0));
    tbl.push_back(vl(0,0,32'h0,0,           0, 1, 0,0));
    tbl.push_back(vl(1,1,32'h4,32'h55AA55AA,0, 1, 1,0));
    tbl.push_back(vl(0,0,32'h0,0,           0, 1, 0,1));
    tbl.push_back(vl(0,0,32'h0,0,           0, 0, 0,0));
`else
    tbl.push_back(vl(0,0,32'h0,0,           0, 1, 0,1));
    tbl.push_back(vl(1,0,32'h4,0,           1, 1, 1,0));
    tbl.push_back(vl(0,0,32'h0,0,           0, 1, 0,1));
    tbl.push_back(vl(1,1,32'h4,32'h55AA55AA,0, 1, 1,0));
    tbl.push_back(vl(0,0,32'h0,0,           0, 1, 0,1));
    tbl.push_back(vl(0,0,32'h0,0,           0, 0, 0,0));
`endif

    foreach (tbl[i]) run_vec(tbl[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
